// File: rtl/mcu_subsys_pkg.sv
// rtl/mcu_subsys_pkg.sv - shared types and constants for the MCU SRAM responder
// Contents:
//   sram_rsp_state_t  responder FSM state encoding
//   MCU_SRAM_REGION   value of addr[31:30] that the host bridge routes to this target
package mcu_subsys_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        RECOVER
    } sram_rsp_state_t;

    localparam logic [1:0] MCU_SRAM_REGION = 2'b01;

endpackage

// File: rtl/mcu_subsys_sram_responder_if.sv
// rtl/mcu_subsys_sram_responder_if.sv - valid/ready memory request bus between host bridge and SRAM target
// Signals:
//   mem_valid  request valid (master -> slave)
//   mem_ready  one-cycle completion strobe (slave -> master)
//   mem_addr   byte address, bits [1:0] ignored
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, 4'h0 = read
//   mem_rdata  read data, meaningful only while mem_ready=1
interface mcu_subsys_sram_responder_if;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/mcu_subsys_sram_array.sv
// rtl/mcu_subsys_sram_array.sv - DEPTH_WORDS x 32 single-port RAM, byte enables, registered read
// Ports:
//   sys_clk  clock
//   en       access enable; read issued and write committed on this edge
//   we       per-byte write enables, honoured only while en=1
//   idx      word index
//   wdata    write data
//   rdata    read data, valid the cycle after en (read-before-write)
module mcu_subsys_sram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          sys_clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // No reset on storage so the array maps onto block RAM.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge sys_clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mcu_subsys_sram_responder.sv
// rtl/mcu_subsys_sram_responder.sv - SRAM target: request FSM, wait states, range check, sticky error
// Ports:
//   sys_clk     system clock
//   rst         synchronous active-high reset
//   mem         slave side of the memory request bus
//   err_clear   clears err_sticky (a simultaneous new error wins)
//   err_sticky  set by any out-of-range access
//   err_addr    address of the first out-of-range access since the last clear
module mcu_subsys_sram_responder
    import mcu_subsys_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ERR_RDATA   = 32'h0
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    mcu_subsys_sram_responder_if.slave         mem,
    input  logic                               err_clear,
    output logic                               err_sticky,
    output logic [31:0]                        err_addr
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    sram_rsp_state_t state;
    logic [3:0]      cnt;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            in_range_q;
    logic            ready_q;

    logic            in_range_now;
    logic            arr_en;
    logic [3:0]      arr_we;
    logic [31:0]     arr_rdata;

    // Bits above the array but below the region select must be zero.
    assign in_range_now = (mem.mem_addr[29:AW+2] == '0);

    // The array op only happens if valid is still held in ACCESS; reset on
    // the same edge suppresses it so an interrupted write never lands.
    assign arr_en = (state == ACCESS) && mem.mem_valid && !rst;
    assign arr_we = (arr_en && in_range_q) ? wstrb_q : 4'h0;

    mcu_subsys_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .sys_clk (sys_clk),
        .en      (arr_en),
        .we      (arr_we),
        .idx     (addr_q[AW+1:2]),
        .wdata   (wdata_q),
        .rdata   (arr_rdata)
    );

    assign mem.mem_ready = ready_q;
    // ready_q is high only in RESP, so rdata is zero outside that cycle.
    assign mem.mem_rdata = (ready_q && (wstrb_q == 4'h0))
                         ? (in_range_q ? arr_rdata : ERR_RDATA)
                         : 32'h0;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            cnt        <= 4'd0;
            err_sticky <= 1'b0;
            err_addr   <= 32'h0;
        end else begin
            ready_q <= 1'b0;

            // Placed before the FSM so an error flagged below overrides it.
            if (err_clear) begin
                err_sticky <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (mem.mem_valid) begin
                        addr_q     <= mem.mem_addr;
                        wdata_q    <= mem.mem_wdata;
                        wstrb_q    <= mem.mem_wstrb;
                        in_range_q <= in_range_now;
                        cnt        <= WS;
                        state      <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (!mem.mem_valid) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!mem.mem_valid) begin
                        state <= IDLE;
                    end else begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        if (!in_range_q) begin
                            err_sticky <= 1'b1;
                            if (!err_sticky) begin
                                err_addr <= addr_q;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= RECOVER;
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_subsys_sram_responder.sv
// tb/tb_mcu_subsys_sram_responder.sv - directed self-checking bench for mcu_subsys_sram_responder
module tb_mcu_subsys_sram_responder;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid1 = 1'b0;
    logic        valid0 = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        err_clear = 1'b0;
    logic        err_clear0 = 1'b0;
    logic        err_sticky1, err_sticky0;
    logic [31:0] err_addr1, err_addr0;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    mcu_subsys_sram_responder_if b1 ();
    mcu_subsys_sram_responder_if b0 ();

    assign b1.mem_valid = valid1;
    assign b1.mem_addr  = addr;
    assign b1.mem_wdata = wdata;
    assign b1.mem_wstrb = wstrb;
    assign b0.mem_valid = valid0;
    assign b0.mem_addr  = addr;
    assign b0.mem_wdata = wdata;
    assign b0.mem_wstrb = wstrb;

    mcu_subsys_sram_responder #(
        .DEPTH_WORDS (4096),
        .WAIT_STATES (1),
        .ERR_RDATA   (32'hDEAD_BEEF)
    ) u_dut1 (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .mem        (b1),
        .err_clear  (err_clear),
        .err_sticky (err_sticky1),
        .err_addr   (err_addr1)
    );

    mcu_subsys_sram_responder #(
        .DEPTH_WORDS (256),
        .WAIT_STATES (0),
        .ERR_RDATA   (32'h0)
    ) u_dut0 (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .mem        (b0),
        .err_clear  (err_clear0),
        .err_sticky (err_sticky0),
        .err_addr   (err_addr0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? b1.mem_ready : b0.mem_ready;
    endfunction

    function automatic logic [31:0] rdt(input bit sel);
        return sel ? b1.mem_rdata : b0.mem_rdata;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One complete request; checks latency, data, and the drop back to idle outputs.
    task automatic req(input bit sel, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int exp_lat, input logic [31:0] exp_rd,
                       input string tag);
        int          lat;
        logic [31:0] rd;
        bit          got;
        lat = 0;
        rd  = 32'h0;
        got = 1'b0;
        addr  = a;
        wdata = d;
        wstrb = s;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            if (rdy(sel)) begin
                got = 1'b1;
                lat = i;
                rd  = rdt(sel);
            end
        end
        valid1    = 1'b0;
        valid0    = 1'b0;
        err_clear = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rd, exp_rd);
        tick();
        chk({tag, "_ready_drop"}, 32'(rdy(sel)), 32'h0);
        chk({tag, "_rdata_drop"}, rdt(sel), 32'h0);
        tick();
    endtask

    initial begin : stim
        bit          seen;
        int          nrdy;
        int          last;
        bit          prev;
        bit          consec;
        logic [31:0] exp_d [3];

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready1", 32'(b1.mem_ready), 32'h0);
        chk("rst_rdata1", b1.mem_rdata, 32'h0);
        chk("rst_sticky1", 32'(err_sticky1), 32'h0);
        chk("rst_eaddr1", err_addr1, 32'h0);
        chk("rst_ready0", 32'(b0.mem_ready), 32'h0);

        // 1: full-word write then read, WAIT_STATES=1 -> latency 3
        req(1'b1, 32'h4000_0010, 32'hA5A5_1234, 4'hF, 3, 32'h0, "t1_wr");
        req(1'b1, 32'h4000_0010, 32'h0, 4'h0, 3, 32'hA5A5_1234, "t1_rd");

        // 2: byte strobes 0101 over 0x11223344 -> 0x11FF33FF
        req(1'b1, 32'h4000_0014, 32'h1122_3344, 4'hF, 3, 32'h0, "t2_wr");
        req(1'b1, 32'h4000_0014, 32'hFFFF_FFFF, 4'b0101, 3, 32'h0, "t2_wrb");
        req(1'b1, 32'h4000_0014, 32'h0, 4'h0, 3, 32'h11FF_33FF, "t2_rd");

        // 3: out-of-range accesses
        req(1'b1, 32'h4001_0000, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, "t3_bad_rd");
        chk("t3_sticky", 32'(err_sticky1), 32'h1);
        chk("t3_eaddr", err_addr1, 32'h4001_0000);
        req(1'b1, 32'h4001_0010, 32'hCAFE_F00D, 4'hF, 3, 32'h0, "t3_bad_wr");
        req(1'b1, 32'h4000_0010, 32'h0, 4'h0, 3, 32'hA5A5_1234, "t3_noalias");
        req(1'b1, 32'h4002_0000, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, "t3_bad_rd2");
        chk("t3_eaddr_kept", err_addr1, 32'h4001_0000);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t3_cleared", 32'(err_sticky1), 32'h0);
        // err_clear held across a new error: the error wins
        err_clear = 1'b1;
        req(1'b1, 32'h4002_0004, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, "t3_errwin");
        chk("t3_errwin_sticky", 32'(err_sticky1), 32'h1);
        chk("t3_errwin_eaddr", err_addr1, 32'h4002_0004);

        // 4: aborts in WAIT and in ACCESS leave the word unchanged
        req(1'b1, 32'h4000_0020, 32'h1357_9BDF, 4'hF, 3, 32'h0, "t4_init");
        addr = 32'h4000_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= b1.mem_ready;
        end
        chk("t4_wait_abort_noready", 32'(seen), 32'h0);
        valid1 = 1'b1;
        tick();
        tick();
        valid1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen |= b1.mem_ready;
        end
        chk("t4_access_abort_noready", 32'(seen), 32'h0);
        req(1'b1, 32'h4000_0020, 32'h0, 4'h0, 3, 32'h1357_9BDF, "t4_rd");

        // 5: reset during ACCESS of a write
        addr = 32'h4000_0020; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        valid1 = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_ready", 32'(b1.mem_ready), 32'h0);
        chk("t5_rdata", b1.mem_rdata, 32'h0);
        chk("t5_sticky", 32'(err_sticky1), 32'h0);
        rst = 1'b0;
        valid1 = 1'b0;
        tick();
        req(1'b1, 32'h4000_0020, 32'h0, 4'h0, 3, 32'h1357_9BDF, "t5_rd");

        // 6: back-to-back reads with valid held, WAIT_STATES=0
        req(1'b0, 32'h4000_0000, 32'h1111_0000, 4'hF, 2, 32'h0, "t6_w0");
        req(1'b0, 32'h4000_0004, 32'h2222_0001, 4'hF, 2, 32'h0, "t6_w1");
        req(1'b0, 32'h4000_0008, 32'h3333_0002, 4'hF, 2, 32'h0, "t6_w2");
        exp_d[0] = 32'h1111_0000;
        exp_d[1] = 32'h2222_0001;
        exp_d[2] = 32'h3333_0002;
        nrdy = 0; last = 0; prev = 1'b0; consec = 1'b0;
        addr = 32'h4000_0000; wstrb = 4'h0;
        valid0 = 1'b1;
        for (int i = 1; i <= 30 && nrdy < 3; i++) begin
            tick();
            if (b0.mem_ready) begin
                if (prev) consec = 1'b1;
                chk("t6_data", b0.mem_rdata, exp_d[nrdy]);
                chk("t6_spacing", 32'(i - last), (nrdy == 0) ? 32'd2 : 32'd4);
                last = i;
                nrdy++;
                addr = 32'h4000_0000 + 32'(nrdy * 4);
            end
            prev = b0.mem_ready;
        end
        valid0 = 1'b0;
        tick();
        if (b0.mem_ready && prev) consec = 1'b1;
        chk("t6_count", 32'(nrdy), 32'd3);
        chk("t6_no_consec_ready", 32'(consec), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
